// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Frame start byte used when the top is not overridden.
    localparam logic [7:0] MAGIC_BYTE = 8'hA5;

    // MAGIC plus the two count bytes that precede the payload.
    localparam int HDR_BYTES = 3;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words. The fourth byte of
// each word is not stored; it is presented directly on the top lane of the
// combinational word output in the same cycle word_valid pulses.
module imem_loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    // Steer each accepted byte into its lane and advance the byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= 2'd0;
            lanes    <= 24'h0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            lanes    <= 24'h0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lanes[7:0]   <= byte_data;
                2'd1:    lanes[15:8]  <= byte_data;
                2'd2:    lanes[23:16] <= byte_data;
                default: lanes        <= lanes;
            endcase
        end
    end

    assign word_valid = byte_valid && (byte_idx == 2'd3);
    assign word       = {byte_data, lanes};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM loader: parses a MAGIC/count/payload/checksum
// frame, writes the payload words to consecutive RAM addresses and releases
// the core from reset only after the checksum matches.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | hunting for MAGIC, other bytes dropped
//   S_CNT_LO | expecting low byte of the word count
//   S_CNT_HI | expecting high byte, count range-checked here
//   S_DATA   | receiving payload, one RAM write per 4 bytes
//   S_CSUM   | expecting the XOR checksum byte
//   S_DONE   | load good, core released, waiting for start
//   S_ERR    | load bad, core held, waiting for start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] MAGIC  = MAGIC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Word counts are 16 bits on the wire, so ADDR_W above 16 is never reachable.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [7:0]  csum;

    logic        rx_fire;
    logic        data_fire;
    logic        pk_clear;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] n_hdr;

    assign rx_ready  = (state != S_DONE) && (state != S_ERR);
    assign rx_fire   = rx_valid && rx_ready;
    assign data_fire = rx_fire && (state == S_DATA);
    assign pk_clear  = rx_fire && (state == S_CNT_HI);
    assign n_hdr     = {rx_data, cnt_lo};

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (data_fire),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame FSM with registered RAM write port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt_lo     <= 8'h00;
            n_words    <= 16'h0000;
            word_idx   <= 16'h0000;
            csum       <= 8'h00;
            mem_addr   <= '0;
            mem_data   <= 32'h0;
            mem_we     <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fire && (rx_data == MAGIC)) begin
                        state <= S_CNT_LO;
                        busy  <= 1'b1;
                    end
                end
                S_CNT_LO: begin
                    if (rx_fire) begin
                        cnt_lo <= rx_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (rx_fire) begin
                        n_words <= n_hdr;
                        if ((n_hdr == 16'h0000) || ({16'h0000, n_hdr} > DEPTH)) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            word_idx <= 16'h0000;
                            csum     <= 8'h00;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        csum <= csum ^ rx_data;
                        if (word_valid) begin
                            mem_we   <= 1'b1;
                            mem_data <= word;
                            mem_addr <= word_idx[ADDR_W-1:0];
                            word_idx <= word_idx + 16'd1;
                            if ((word_idx + 16'd1) == n_words) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_fire) begin
                        busy <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state      <= S_IDLE;
                        done       <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state <= S_IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames,
// compared against a whole-stream frame parser.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_we;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_total = 0;

    always @(negedge clk) if (mem_we) we_total++;

    // Reference results for the stream currently being sent.
    int          wr_k[$];       // per byte: index of the word it completes, or -1
    logic [31:0] exp_data[$];   // expected RAM writes, in order, address = index
    int          exp_res;       // 0 = unfinished, 1 = done, 2 = err

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Parse a whole byte stream by the frame rules.
    function automatic void model(input logic [7:0] s[$]);
        int p;
        int n;
        int b0;
        logic [7:0] x;
        wr_k.delete();
        exp_data.delete();
        exp_res = 0;
        foreach (s[i]) wr_k.push_back(-1);
        p = 0;
        while (p < s.size() && s[p] != MAGIC_BYTE) p++;
        if (p + HDR_BYTES > s.size()) return;
        n = int'(s[p+1]) + 256 * int'(s[p+2]);
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_res = 2;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            b0 = p + HDR_BYTES + 4 * k;
            if (b0 + 3 >= s.size()) return;
            exp_data.push_back({s[b0+3], s[b0+2], s[b0+1], s[b0]});
            wr_k[b0+3] = k;
            x = x ^ s[b0] ^ s[b0+1] ^ s[b0+2] ^ s[b0+3];
        end
        b0 = p + HDR_BYTES + 4 * n;
        if (b0 < s.size()) exp_res = (s[b0] == x) ? 1 : 2;
    endfunction

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        int we0;
        int g;
        model(s);
        we0 = we_total;
        foreach (s[i]) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("we_in_gap", 32'(mem_we), 32'd0);
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[i];
            chk("rx_ready_during_frame", 32'(rx_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("mem_we_latency", 32'(mem_we), 32'(wr_k[i] >= 0));
            if (wr_k[i] >= 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(wr_k[i]));
                chk("mem_data", mem_data, exp_data[wr_k[i]]);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        chk("n_writes", 32'(we_total - we0), 32'(exp_data.size()));
        chk("done", 32'(done), 32'(exp_res == 1));
        chk("err", 32'(err), 32'(exp_res == 2));
        chk("core_reset", 32'(core_reset), 32'(exp_res != 1));
        chk("rx_ready_after", 32'(rx_ready), 32'(exp_res == 0));
        if (exp_res != 0) chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(err), 32'd0);
        chk("start_core_reset", 32'(core_reset), 32'd1);
        chk("start_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [7:0]  junk;
        logic [31:0] w;
        int          n;

        do_reset();

        // Two words; XOR of 13,00,00,00,B3,00,50,00 is F0.
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        send_stream(q, 0);
        pulse_start();

        // Leading garbage is dropped.
        q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h6F};
        send_stream(q, 0);
        pulse_start();

        // Bad checksum: word still written, then ERR.
        q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(q, 0);
        pulse_start();

        // Zero count.
        q = '{8'hA5, 8'h00, 8'h00};
        send_stream(q, 0);
        pulse_start();

        // Count one past the RAM depth.
        q = '{8'hA5, 8'h01, 8'h10};
        send_stream(q, 0);
        pulse_start();

        // Reset mid-word, then a clean one-word frame.
        q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_stream(q, 0);
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset();
        q = '{8'hA5, 8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
        send_stream(q, 0);
        pulse_start();

        // First frame again with random valid gaps.
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        send_stream(q, 5);
        pulse_start();

        // Random frames, some with a junk prefix or a corrupted checksum.
        for (int it = 0; it < 8; it++) begin
            q.delete();
            if ($urandom_range(1, 0) == 1) begin
                junk = 8'($urandom_range(255, 0));
                if (junk == MAGIC_BYTE) junk = 8'h00;
                q.push_back(junk);
            end
            n = int'($urandom_range(6, 1));
            q.push_back(MAGIC_BYTE);
            q.push_back(8'(n));
            q.push_back(8'h00);
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                w = $urandom();
                q.push_back(w[7:0]);
                q.push_back(w[15:8]);
                q.push_back(w[23:16]);
                q.push_back(w[31:24]);
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
            if ($urandom_range(2, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
            q.push_back(x);
            send_stream(q, 3);
            pulse_start();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
